// File: rtl/step_ctrl_pkg.sv
// Shared constants for the CPU step controller: mode encoding (also decoded
// by the core's debug/LED logic) and the default button debounce length.
package step_ctrl_pkg;

   localparam int MODE_W = 2;

   localparam logic [MODE_W-1:0] ST_PAUSE = 2'b00;
   localparam logic [MODE_W-1:0] ST_RUN   = 2'b01;
   localparam logic [MODE_W-1:0] ST_HALT  = 2'b10;

   // 10 ms at 100 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

   typedef enum logic [MODE_W-1:0] {
      S_PAUSE = ST_PAUSE,
      S_RUN   = ST_RUN,
      S_HALT  = ST_HALT
   } step_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: two-flop synchronizer, hold-time debounce and a
// one-cycle press pulse on the rising edge of the accepted level.
module btn_debounce
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   // bring the asynchronous button into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= btn_raw;
         sync_2 <= sync_1;
      end
   end

   // accept a new level only after it has differed from the current one long enough
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_level <= 1'b0;
         cnt       <= '0;
      end else if (sync_2 == btn_level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         btn_level <= sync_2;
         cnt       <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // delayed copy of the accepted level for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
      end else begin
         level_q <= btn_level;
      end
   end

   // release is deliberately not reported; only the press edge matters
   assign btn_press = btn_level & ~level_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the multicycle core: free-run on the divided
// tick, single-step on the debounced button, sticky halt from the core.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_PAUSE | core frozen; each button press issues one cpu_ce
//   S_RUN   | one cpu_ce per rising edge of tick_in
//   S_HALT  | core executed a halt; no cpu_ce until reset
//   2'b11   | unreachable; falls back to S_PAUSE
module cpu_step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_in,
   input  logic              btn_step,
   input  logic              sw_run,
   input  logic              cpu_halt,
   output logic              cpu_ce,
   output logic [MODE_W-1:0] mode,
   output logic [15:0]       ce_count
);

   step_state_e state;

   logic tick_s;
   logic tick_q;
   logic tick_rise;
   logic btn_press;
   logic btn_level_unused;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_step),
      .btn_level (btn_level_unused),
      .btn_press (btn_press)
   );

   // capture the tick and keep a delayed copy; both reset high so a tick
   // already high when reset is released is not seen as an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_s <= 1'b1;
         tick_q <= 1'b1;
      end else begin
         tick_s <= tick_in;
         tick_q <= tick_s;
      end
   end

   assign tick_rise = tick_s & ~tick_q;

   // mode FSM with registered enable pulse and pulse counter; halt beats a
   // mode change, which beats a pulse request (colliding events are dropped)
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_PAUSE;
         cpu_ce   <= 1'b0;
         ce_count <= '0;
      end else begin
         cpu_ce <= 1'b0;
         case (state)
            S_PAUSE: begin
               if (cpu_halt) begin
                  state <= S_HALT;
               end else if (sw_run) begin
                  state <= S_RUN;
               end else if (btn_press) begin
                  cpu_ce   <= 1'b1;
                  ce_count <= ce_count + 16'd1;
               end
            end
            S_RUN: begin
               if (cpu_halt) begin
                  state <= S_HALT;
               end else if (!sw_run) begin
                  state <= S_PAUSE;
               end else if (tick_rise) begin
                  cpu_ce   <= 1'b1;
                  ce_count <= ce_count + 16'd1;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_PAUSE;
            end
         endcase
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus randomized stimulus, with
// a cycle-level behavioural model compared against the DUT every cycle.
module tb_cpu_step_ctrl;

   localparam int DB = 4;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        tick_in  = 1'b1;
   logic        btn_step = 1'b0;
   logic        sw_run   = 1'b0;
   logic        cpu_halt = 1'b0;
   logic        cpu_ce;
   logic [1:0]  mode;
   logic [15:0] ce_count;

   cpu_step_ctrl #(
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_in  (tick_in),
      .btn_step (btn_step),
      .sw_run   (sw_run),
      .cpu_halt (cpu_halt),
      .cpu_ce   (cpu_ce),
      .mode     (mode),
      .ce_count (ce_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state (mode 0 = pause, 1 = run, 2 = halt)
   bit model_on = 1'b0;
   int exp_mode = 0;
   bit exp_ce   = 1'b0;
   int exp_cnt  = 0;
   bit m_tick1, m_tick2;     // tick_in seen one and two edges ago
   bit m_sync1, m_sync2;     // button seen one and two edges ago
   bit m_lvl, m_lvl_prev;    // accepted button level now / one edge ago
   int m_run;                // consecutive samples differing from accepted level
   bit pre_req  = 1'b0;
   bit pre_seen = 1'b0;
   int pre_val  = 0;
   bit skip_cmp = 1'b0;

   bit ce_s;
   int mode_s;
   int cnt_s;

   always @(posedge clk) begin : model
      bit tick_ev, press_ev, nce, lvl_n;
      int nmode, ncnt, nrun;
      if (rst) begin
         model_on   <= 1'b1;
         exp_mode   <= 0;
         exp_ce     <= 1'b0;
         exp_cnt    <= 0;
         m_tick1    <= 1'b1;
         m_tick2    <= 1'b1;
         m_sync1    <= 1'b0;
         m_sync2    <= 1'b0;
         m_lvl      <= 1'b0;
         m_lvl_prev <= 1'b0;
         m_run      <= 0;
      end else if (model_on) begin
         tick_ev  = m_tick1 & ~m_tick2;
         press_ev = m_lvl & ~m_lvl_prev;
         nmode = exp_mode;
         ncnt  = exp_cnt;
         nce   = 1'b0;
         if (pre_req != pre_seen) ncnt = pre_val;
         if (exp_mode == 2) nmode = 2;
         else if (cpu_halt) nmode = 2;
         else if (sw_run != (exp_mode == 1)) nmode = sw_run ? 1 : 0;
         else if (exp_mode == 1 ? tick_ev : press_ev) begin
            nce  = 1'b1;
            ncnt = (ncnt + 1) % 65536;
         end
         lvl_n = m_lvl;
         nrun  = 0;
         if (m_sync2 != m_lvl) begin
            nrun = m_run + 1;
            if (nrun == DB) begin
               lvl_n = m_sync2;
               nrun  = 0;
            end
         end
         exp_mode   <= nmode;
         exp_ce     <= nce;
         exp_cnt    <= ncnt;
         pre_seen   <= pre_req;
         m_tick2    <= m_tick1;
         m_tick1    <= tick_in;
         m_lvl_prev <= m_lvl;
         m_lvl      <= lvl_n;
         m_run      <= nrun;
         m_sync2    <= m_sync1;
         m_sync1    <= btn_step;
      end
   end

   // one clock: sample and compare at negedge, return 1 time unit after posedge
   task automatic step_cyc();
      @(negedge clk);
      ce_s   = cpu_ce;
      mode_s = int'(mode);
      cnt_s  = int'(ce_count);
      if (model_on && !skip_cmp) begin
         total++;
         if (cpu_ce !== exp_ce || mode !== 2'(exp_mode) || ce_count !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL cycle t=%0t ce=%b want=%b mode=%0d want=%0d count=%0d want=%0d",
                     $time, cpu_ce, exp_ce, mode, exp_mode, ce_count, exp_cnt);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // raise tick for 8 cycles, lower for 8; report first-pulse index and pulse count
   task automatic tick_pulse(output int lat, output int n);
      lat = 0;
      n   = 0;
      tick_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step_cyc();
         if (ce_s) begin
            n++;
            if (lat == 0) lat = i;
         end
      end
      tick_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step_cyc();
         if (ce_s) n++;
      end
   endtask

   initial begin
      int lat, n, tl, bl;

      // reset with tick already high
      rst = 1'b1;
      tick_in = 1'b1;
      repeat (3) step_cyc();
      rst = 1'b0;
      n = 0;
      repeat (10) begin
         step_cyc();
         if (ce_s) n++;
      end
      check("rst_tick_high_pulses", n, 0);
      check("rst_mode", mode_s, 0);
      check("rst_count", cnt_s, 0);

      // free-run: five tick edges
      sw_run  = 1'b1;
      tick_in = 1'b0;
      repeat (8) step_cyc();
      check("run_mode", mode_s, 1);
      for (int k = 0; k < 5; k++) begin
         tick_pulse(lat, n);
         check("run_latency", lat, 3);
         check("run_width", n, 1);
      end
      check("run_count", cnt_s, 5);

      // single step with a 1-0-1 bounce
      sw_run = 1'b0;
      repeat (4) step_cyc();
      btn_step = 1'b1;
      step_cyc();
      btn_step = 1'b0;
      step_cyc();
      btn_step = 1'b1;
      lat = 0;
      n   = 0;
      for (int i = 1; i <= 20; i++) begin
         step_cyc();
         if (ce_s) begin
            n++;
            if (lat == 0) lat = i;
         end
      end
      check("step_latency", lat, 8);
      check("step_pulses", n, 1);
      btn_step = 1'b0;
      n = 0;
      repeat (20) begin
         step_cyc();
         if (ce_s) n++;
      end
      check("release_pulses", n, 0);
      check("step_count", cnt_s, 6);

      // randomized traffic, including occasional mid-operation resets
      tl = 1;
      bl = 1;
      for (int c = 0; c < 1500; c++) begin
         tl--;
         if (tl == 0) begin
            tick_in = ~tick_in;
            tl = $urandom_range(1, 6);
         end
         bl--;
         if (bl == 0) begin
            btn_step = 1'($urandom_range(0, 1));
            bl = $urandom_range(1, 10);
         end
         if ($urandom_range(0, 59) == 0) sw_run = ~sw_run;
         rst = ($urandom_range(0, 299) == 0);
         step_cyc();
      end
      rst = 1'b0;

      // press arriving on the same cycle sw_run goes 0 -> 1
      sw_run   = 1'b0;
      btn_step = 1'b0;
      tick_in  = 1'b0;
      repeat (12) step_cyc();
      btn_step = 1'b1;
      repeat (6) step_cyc();
      sw_run = 1'b1;
      n = 0;
      repeat (10) begin
         step_cyc();
         if (ce_s) n++;
      end
      check("collide_pulses", n, 0);
      check("collide_mode", mode_s, 1);
      tick_pulse(lat, n);
      check("collide_tick_latency", lat, 3);
      btn_step = 1'b0;

      // counter wrap: start near the top of the range
      repeat (4) step_cyc();
      force dut.ce_count = 16'hFFFC;
      pre_val  = 16'hFFFC;
      pre_req  = ~pre_req;
      skip_cmp = 1'b1;
      step_cyc();
      release dut.ce_count;
      skip_cmp = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick_pulse(lat, n);
         check("wrap_width", n, 1);
      end
      check("wrap_count", cnt_s, 0);
      tick_pulse(lat, n);
      check("post_wrap_count", cnt_s, 1);

      // halt arriving with a tick edge, then sticky until reset
      tick_in = 1'b1;
      step_cyc();
      cpu_halt = 1'b1;
      n = 0;
      repeat (8) begin
         step_cyc();
         if (ce_s) n++;
      end
      cpu_halt = 1'b0;
      tick_in  = 1'b0;
      check("halt_collide_pulses", n, 0);
      check("halt_mode", mode_s, 2);
      repeat (3) begin
         tick_pulse(lat, bl);
         n += bl;
      end
      btn_step = 1'b1;
      repeat (15) begin
         step_cyc();
         if (ce_s) n++;
      end
      btn_step = 1'b0;
      sw_run   = 1'b0;
      repeat (15) begin
         step_cyc();
         if (ce_s) n++;
      end
      check("halt_sticky_pulses", n, 0);
      check("halt_sticky_mode", mode_s, 2);
      rst = 1'b1;
      repeat (2) step_cyc();
      rst = 1'b0;
      step_cyc();
      check("halt_rst_mode", mode_s, 0);
      check("halt_rst_count", cnt_s, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
